neopixel_control_mc: RTL and testbench
======================================

Name: neopixel_control_mc

Overview:
Multi-channel, parametrised successor to the single-strip neopixel command front end. It takes 32-bit pixel-write words from the AXI side into an inferred synchronous FIFO, decodes each word into a channel, pixel index and colour, and issues it to one of C_CHANNELS neopixel drivers. Each driver gets its own strobe and ready signal. Additions over the previous generation:
- honours per-channel ctrl_ready backpressure;
- drops and counts out-of-range addresses;
- detects FIFO overflow;
- supports a broadcast command that writes one colour to every pixel of every channel.

Parameters:
- C_CHANNELS, 4: number of neopixel strips/drivers (1..16).
- C_PIXELS, 12: pixels per channel (2..128).
- C_FIFO_DEPTH, 16: command FIFO depth in words; power of 2, minimum 4.
- C_COLOR_W, 24: colour field width (24 for GRB, 32 for GRBW); C_COLOR_W <= 24 when packed in a 32-bit word.
- C_BCAST_EN, 1: 1 = address 8'hFF is the broadcast command; 0 = 8'hFF is decoded normally.
- Derived C_PIX_AW = clog2(C_PIXELS). Elaboration assertion: C_CHANNELS <= 2^(8-C_PIX_AW).

Ports:
- axi_clock, in, 1: single clock for the whole block.
- axi_reset_n, in, 1: reset, asynchronous assert, active-low.
- axi_data, in, 32: command word. [31:24] = address, [23:0] = colour (low C_COLOR_W bits used).
- axi_write_en, in, 1: push axi_data.
- axi_full, out, 1: FIFO full, registered.
- fifo_level, out, clog2(C_FIFO_DEPTH)+1: FIFO occupancy.
- ctrl_write_en, out, C_CHANNELS: one-hot write strobe, bit n targets channel n.
- ctrl_address, out, 8: pixel index, zero-extended, shared by all channels.
- ctrl_write_data, out, C_COLOR_W: colour, shared by all channels.
- ctrl_ready, in, C_CHANNELS: per-channel driver ready.
- err_clear, in, 1: clears err_overflow and err_drop_count.
- err_overflow, out, 1: sticky, set when a push is attempted while full.
- err_drop_count, out, 16: count of out-of-range commands discarded; saturates at 16'hFFFF.

Behaviour:

Reset:
- Asynchronous assert, synchronous release. Reset clears FIFO pointers, FSM (to S_IDLE), all outputs and error state.
- Reset values: ctrl_write_en=0, ctrl_address=0, ctrl_write_data=0, axi_full=0, fifo_level=0, err_*=0.
- Reset mid-operation aborts any issue or broadcast immediately, discards FIFO contents, and drops strobes in the same instant.

FIFO:
- A push is accepted iff axi_write_en=1 and axi_full=0 at the sampling edge. A same-edge pop does not make room.
- Rejected push: the word is discarded and err_overflow is set.
- Read data is registered and valid one cycle after the pop.

Decode of a latched word:
- ch = addr[7:C_PIX_AW], px = addr[C_PIX_AW-1:0].
- Out of range when ch >= C_CHANNELS or px >= C_PIXELS. Broadcast is excluded from this check when C_BCAST_EN=1.

FSM:
- S_IDLE: if FIFO not empty, pop and go to S_FETCH.
- S_FETCH: latch the word.
  - Broadcast: go to S_BCAST with ch=0, px=0.
  - Out of range: increment err_drop_count (saturating) and return to S_IDLE.
  - Otherwise: go to S_ISSUE.
- S_ISSUE: wait while ctrl_ready[ch]=0, outputs idle. When ready=1, on the next edge drive ctrl_write_en[ch]=1 for exactly one cycle, with ctrl_address=px and ctrl_write_data=colour; go to S_IDLE.
- S_BCAST: on each cycle with ctrl_ready[ch]=1, strobe (ch, px).
  - Advancing: px+1; when px = C_PIXELS-1, wrap px to 0 and step ch+1.
  - After (C_CHANNELS-1, C_PIXELS-1), return to S_IDLE.
  - While ready is low, hold the current (ch, px).

Timing:
- Latency: push at edge E into an empty FIFO with the FSM idle and ready high gives ctrl_write_en high in the cycle following edge E+3.
- Sustained throughput: one command per 3 cycles.
- Broadcast: C_CHANNELS*C_PIXELS consecutive strobes when ready is held high.

Ordering and error rules:
- Commands are issued strictly in FIFO order.
- At most one ctrl_write_en bit is high at any time.
- err_clear together with a new error event on the same edge: the event wins (flag set, counter = 1).
- Effective buffering while the FSM is stalled = C_FIFO_DEPTH + 1, since one word is held in S_ISSUE.

Decomposition:
- Package neopixel_pkg holds:
  - the state enum (S_IDLE, S_FETCH, S_ISSUE, S_BCAST);
  - BCAST_ADDR = 8'hFF;
  - field constants ADDR_MSB=31, ADDR_LSB=24, COLOR_LSB=0;
  - a clog2 function.
- One sub-module, neopixel_sync_fifo (parameters width and depth; registered read; full, empty and level outputs).
- Decode, FSM and error logic live in the top level.

Test Plan (C_CHANNELS=4, C_PIXELS=12, C_FIFO_DEPTH=16, C_COLOR_W=24, C_PIX_AW=4):
1. Ready all 1; push 32'h21_00FF00 -> exactly one cycle with ctrl_write_en=4'b0100, ctrl_address=8'h01, ctrl_write_data=24'h00FF00, 3 edges after the push.
2. Push 32'h1C_123456 (px 12) and 32'h50_123456 (ch 5), then 32'h00_ABCDEF -> no strobes for the first two; err_drop_count=2; then one strobe ch0/px0 with data 24'hABCDEF.
3. Push 32'hFF_123456, ready high -> 48 consecutive strobes covering (0,0)..(3,11) in order, all carrying 24'h123456. Repeat with ctrl_ready[2] low for 10 cycles mid-broadcast -> sequence pauses at channel 2 with no skips or duplicates.
4. Ready low; 18 back-to-back pushes -> axi_full=1, fifo_level=16, err_overflow=1, 18th word lost. Raise ready -> 17 strobes in push order. err_clear -> err flags return to 0.
5. Broadcast in progress; assert axi_reset_n=0 asynchronously -> ctrl_write_en=0 immediately, fifo_level=0. After release, a fresh push 32'h30_000001 produces a single strobe on ch3/px0.
6. C_BCAST_EN=0; push 32'hFF_000000 -> dropped as out of range; err_drop_count increments by 1.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared types and constants for the multi-channel neopixel command front end.
package neopixel_pkg;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_BCAST} state_t;

  localparam logic [7:0] BCAST_ADDR = 8'hFF;
  localparam int ADDR_MSB  = 31;
  localparam int ADDR_LSB  = 24;
  localparam int COLOR_LSB = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/neopixel_control_mc_if.sv
// Command-side and driver-side signals of neopixel_control_mc, bundled as one port.
interface neopixel_control_mc_if #(
  parameter int C_CHANNELS   = 4,
  parameter int C_COLOR_W    = 24,
  parameter int C_FIFO_DEPTH = 16
);
  import neopixel_pkg::*;

  localparam int LVL_W = clog2(C_FIFO_DEPTH) + 1;

  logic [31:0]           axi_data;
  logic                  axi_write_en;
  logic                  axi_full;
  logic [LVL_W-1:0]      fifo_level;
  logic [C_CHANNELS-1:0] ctrl_write_en;
  logic [7:0]            ctrl_address;
  logic [C_COLOR_W-1:0]  ctrl_write_data;
  logic [C_CHANNELS-1:0] ctrl_ready;
  logic                  err_clear;
  logic                  err_overflow;
  logic [15:0]           err_drop_count;

  modport master (
    output axi_data, axi_write_en, ctrl_ready, err_clear,
    input  axi_full, fifo_level, ctrl_write_en, ctrl_address, ctrl_write_data,
           err_overflow, err_drop_count
  );

  modport slave (
    input  axi_data, axi_write_en, ctrl_ready, err_clear,
    output axi_full, fifo_level, ctrl_write_en, ctrl_address, ctrl_write_data,
           err_overflow, err_drop_count
  );

endinterface

// File: rtl/neopixel_sync_fifo.sv
// Single-clock FIFO with registered read data and registered full flag.
module neopixel_sync_fifo
  import neopixel_pkg::*;
#(
  parameter int  W     = 32,
  parameter int  DEPTH = 16,
  localparam int AW    = clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level, w_level_nxt;
  logic [W-1:0]  r_rd_data;
  logic          r_full, w_push, w_pop;

  // Push is gated by the registered full flag, so a same-edge pop never makes room.
  assign w_push      = i_wr_en && !r_full;
  assign w_pop       = i_rd_en && (r_level != '0);
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr    <= r_rptr + AW'(1);
        r_rd_data <= r_mem[r_rptr];
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_full    = r_full;
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;

endmodule

// File: rtl/neopixel_control_mc.sv
// Multi-channel neopixel command front end: FIFO, address decode, per-channel
// issue with backpressure, broadcast fill and error accounting.
module neopixel_control_mc
  import neopixel_pkg::*;
#(
  parameter int C_CHANNELS   = 4,
  parameter int C_PIXELS     = 12,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_COLOR_W    = 24,
  parameter int C_BCAST_EN   = 1
) (
  input logic axi_clock,
  input logic axi_reset_n,
  neopixel_control_mc_if.slave bus
);

  localparam int         C_PIX_AW = clog2(C_PIXELS);
  localparam logic [7:0] CH_LAST  = 8'(C_CHANNELS - 1);
  localparam logic [7:0] PX_LAST  = 8'(C_PIXELS - 1);
  localparam logic [7:0] PX_MASK  = 8'((1 << C_PIX_AW) - 1);

  if (C_CHANNELS > (1 << (8 - C_PIX_AW)) || C_COLOR_W > 24) begin : g_bad_cfg
    $error("neopixel_control_mc: channel/pixel/colour parameters do not fit the command word");
  end

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_ch, r_px, w_ch_nxt, w_px_nxt;
  logic [C_COLOR_W-1:0]  r_color, w_color_nxt;
  logic [C_CHANNELS-1:0] r_we, w_we_nxt, w_sel;
  logic [7:0]            r_addr, w_addr_nxt;
  logic [C_COLOR_W-1:0]  r_data, w_data_nxt;
  logic                  r_ovf;
  logic [15:0]           r_drops;
  logic [31:0]           w_rd_data;
  logic [7:0]            w_addr, w_ch, w_px;
  logic                  w_empty, w_pop, w_drop, w_bcast, w_oor, w_rdy;

  neopixel_sync_fifo #(.W(32), .DEPTH(C_FIFO_DEPTH)) u_fifo (
    .i_clk     (axi_clock),
    .i_rst_n   (axi_reset_n),
    .i_wr_en   (bus.axi_write_en),
    .i_wr_data (bus.axi_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (bus.axi_full),
    .o_empty   (w_empty),
    .o_level   (bus.fifo_level)
  );

  assign w_addr  = w_rd_data[ADDR_MSB:ADDR_LSB];
  assign w_ch    = w_addr >> C_PIX_AW;
  assign w_px    = w_addr & PX_MASK;
  assign w_bcast = (C_BCAST_EN != 0) && (w_addr == BCAST_ADDR);
  assign w_oor   = (w_ch > CH_LAST) || (w_px > PX_LAST);
  assign w_sel   = C_CHANNELS'(1) << r_ch;
  assign w_rdy   = |(bus.ctrl_ready & w_sel);

  always_ff @(posedge axi_clock or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_px    <= '0;
      r_color <= '0;
      r_we    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_px    <= w_px_nxt;
      r_color <= w_color_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_px_nxt    = r_px;
    w_color_nxt = r_color;
    w_we_nxt    = '0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_pop       = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_color_nxt = w_rd_data[COLOR_LSB +: C_COLOR_W];
        if (w_bcast) begin
          w_ch_nxt    = '0;
          w_px_nxt    = '0;
          w_state_nxt = S_BCAST;
        end else if (w_oor) begin
          w_drop      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_ch_nxt    = w_ch;
          w_px_nxt    = w_px;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_rdy) begin
          w_we_nxt    = w_sel;
          w_addr_nxt  = r_px;
          w_data_nxt  = r_color;
          w_state_nxt = S_IDLE;
        end
      end
      S_BCAST: begin
        // Walk pixels within a channel, then channels; a stalled channel holds position.
        if (w_rdy) begin
          w_we_nxt   = w_sel;
          w_addr_nxt = r_px;
          w_data_nxt = r_color;
          if (r_px == PX_LAST) begin
            w_px_nxt = '0;
            if (r_ch == CH_LAST) w_state_nxt = S_IDLE;
            else                 w_ch_nxt    = r_ch + 8'd1;
          end else begin
            w_px_nxt = r_px + 8'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A new error event on the same edge as err_clear takes priority over the clear.
  always_ff @(posedge axi_clock or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_ovf   <= 1'b0;
      r_drops <= '0;
    end else begin
      if (bus.axi_write_en && bus.axi_full) r_ovf <= 1'b1;
      else if (bus.err_clear)               r_ovf <= 1'b0;
      if (w_drop) begin
        if (bus.err_clear)              r_drops <= 16'd1;
        else if (r_drops != 16'hFFFF)   r_drops <= r_drops + 16'd1;
      end else if (bus.err_clear) begin
        r_drops <= '0;
      end
    end
  end

  assign bus.ctrl_write_en   = r_we;
  assign bus.ctrl_address    = r_addr;
  assign bus.ctrl_write_data = r_data;
  assign bus.err_overflow    = r_ovf;
  assign bus.err_drop_count  = r_drops;

endmodule

// File: tb/tb_neopixel_control_mc.sv
// Bench for neopixel_control_mc: decode table, hand-written corner sequences and
// randomized traffic scored against a queue-based model of the command stream.
module tb_neopixel_control_mc;

  localparam int NC   = 4;
  localparam int NP   = 12;
  localparam int SPAN = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_b = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_drops = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neopixel_control_mc_if #(.C_CHANNELS(NC), .C_COLOR_W(24), .C_FIFO_DEPTH(16)) bus ();
  neopixel_control_mc_if #(.C_CHANNELS(NC), .C_COLOR_W(24), .C_FIFO_DEPTH(16)) bus_b ();

  neopixel_control_mc #(.C_CHANNELS(NC), .C_PIXELS(NP), .C_FIFO_DEPTH(16),
                        .C_COLOR_W(24), .C_BCAST_EN(1))
    dut (.axi_clock(clk), .axi_reset_n(rst_n), .bus(bus));

  neopixel_control_mc #(.C_CHANNELS(NC), .C_PIXELS(NP), .C_FIFO_DEPTH(16),
                        .C_COLOR_W(24), .C_BCAST_EN(0))
    dut_b (.axi_clock(clk), .axi_reset_n(rst_n_b), .bus(bus_b));

  typedef struct { int ch; int px; logic [23:0] d; int cyc; } strb_t;
  typedef struct { logic [31:0] w; bit ok; logic [3:0] we; logic [7:0] a; } vec_t;

  strb_t act_q[$];
  strb_t exp_q[$];
  strb_t nb_last;
  int    nb_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [63:0] pk(input strb_t s);
    return 64'({8'(s.ch), 8'(s.px), s.d});
  endfunction

  // Reference: what a word pushed into the block should eventually produce.
  function automatic void model_push(input logic [31:0] w);
    int a;
    a = int'(w[31:24]);
    if (a == 255) begin
      for (int c = 0; c < NC; c++)
        for (int p = 0; p < NP; p++) exp_q.push_back('{c, p, w[23:0], 0});
    end else if (a / SPAN < NC && a % SPAN < NP) begin
      exp_q.push_back('{a / SPAN, a % SPAN, w[23:0], 0});
    end else begin
      exp_drops++;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.ctrl_write_en != '0) begin
      chk("onehot", 64'($countones(bus.ctrl_write_en)), 64'd1);
      act_q.push_back('{oh2idx(bus.ctrl_write_en), int'(bus.ctrl_address),
                        bus.ctrl_write_data, cyc});
    end
    if (rst_n_b && bus_b.ctrl_write_en != '0) begin
      nb_cnt++;
      nb_last = '{oh2idx(bus_b.ctrl_write_en), int'(bus_b.ctrl_address),
                  bus_b.ctrl_write_data, cyc};
    end
  end

  task automatic push(input logic [31:0] w);
    @(negedge clk);
    bus.axi_data     = w;
    bus.axi_write_en = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.axi_write_en = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget, input bit span);
    int t;
    t = 0;
    while (act_q.size() < exp_q.size() && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    repeat (8) @(negedge clk);
    #1;
    chk({nm, " count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("%s strobe%0d", nm, i), pk(act_q[i]), pk(exp_q[i]));
    if (span && act_q.size() == exp_q.size() && act_q.size() > 0)
      chk({nm, " span"}, act_q[act_q.size()-1].cyc - act_q[0].cyc, exp_q.size() - 1);
    chk({nm, " drops"}, bus.err_drop_count, exp_drops);
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[8];
    logic [31:0] w;
    logic [7:0]  a;
    int          r, t, sent;

    vt[0] = '{32'h2100FF00, 1'b1, 4'b0100, 8'h01};
    vt[1] = '{32'h1C123456, 1'b0, 4'b0000, 8'h00};
    vt[2] = '{32'h50123456, 1'b0, 4'b0000, 8'h00};
    vt[3] = '{32'h00ABCDEF, 1'b1, 4'b0001, 8'h00};
    vt[4] = '{32'h3B0000AA, 1'b1, 4'b1000, 8'h0B};
    vt[5] = '{32'h0B5A5A5A, 1'b1, 4'b0001, 8'h0B};
    vt[6] = '{32'h40FFFFFF, 1'b0, 4'b0000, 8'h00};
    vt[7] = '{32'h2F010203, 1'b0, 4'b0000, 8'h00};

    bus.axi_data = '0;   bus.axi_write_en = 1'b0;   bus.ctrl_ready = '1;   bus.err_clear = 1'b0;
    bus_b.axi_data = '0; bus_b.axi_write_en = 1'b0; bus_b.ctrl_ready = '1; bus_b.err_clear = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst we",    bus.ctrl_write_en, 0);
    chk("rst addr",  bus.ctrl_address, 0);
    chk("rst data",  bus.ctrl_write_data, 0);
    chk("rst full",  bus.axi_full, 0);
    chk("rst level", bus.fifo_level, 0);
    chk("rst ovf",   bus.err_overflow, 0);
    chk("rst drops", bus.err_drop_count, 0);
    rst_n = 1'b1;
    rst_n_b = 1'b1;

    // Single commands: strobe exactly in the cycle after the third edge past the push.
    for (int v = 0; v < 8; v++) begin
      push(vt[v].w);
      if (!vt[v].ok) exp_drops++;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (k == 0) bus.axi_write_en = 1'b0;
        #1;
        chk($sformatf("vec%0d we@%0d", v, k), bus.ctrl_write_en, (k == 3) ? vt[v].we : 4'b0);
        if (k == 3 && vt[v].ok) begin
          chk($sformatf("vec%0d addr", v), bus.ctrl_address, vt[v].a);
          chk($sformatf("vec%0d data", v), bus.ctrl_write_data, vt[v].w[23:0]);
        end
      end
      chk($sformatf("vec%0d drops", v), bus.err_drop_count, exp_drops);
    end
    act_q.delete();

    // Back-to-back out-of-range words followed by a valid one.
    push(32'h1C123456); model_push(32'h1C123456);
    push(32'h50123456); model_push(32'h50123456);
    push(32'h00ABCDEF); model_push(32'h00ABCDEF);
    idle();
    drain("oor_seq", 100, 1'b0);

    // err_clear on the same edge as a drop: the drop wins and the counter restarts at 1.
    push(32'h1C000000);
    @(negedge clk); bus.axi_write_en = 1'b0;
    @(negedge clk); bus.err_clear = 1'b1;
    @(negedge clk); bus.err_clear = 1'b0;
    #1;
    chk("clear_vs_drop", bus.err_drop_count, 1);
    exp_drops = 1;

    // Broadcast with ready held high, then with channel 2 stalled mid-way.
    push(32'hFF123456); model_push(32'hFF123456);
    idle();
    drain("bcast", 200, 1'b1);

    push(32'hFF654321); model_push(32'hFF654321);
    idle();
    t = 0;
    while (act_q.size() < 20 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    bus.ctrl_ready[2] = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("bcast stall hold", act_q.size(), 24);
    bus.ctrl_ready = '1;
    drain("bcast_stall", 200, 1'b0);

    // Overflow: 18 pushes with every driver stalled; 17 fit, the last is lost.
    @(negedge clk);
    bus.ctrl_ready = '0;
    for (int i = 0; i < 18; i++) begin
      w = {4'(i % 4), 4'(i % 12), 8'h00, 8'(i), 8'hC3};
      push(w);
      if (i < 17) model_push(w);
    end
    idle();
    #1;
    chk("ovf full",    bus.axi_full, 1);
    chk("ovf level",   bus.fifo_level, 16);
    chk("ovf flag",    bus.err_overflow, 1);
    chk("ovf stalled", act_q.size(), 0);
    bus.ctrl_ready = '1;
    drain("ovf_drain", 200, 1'b0);
    @(negedge clk); bus.err_clear = 1'b1;
    @(negedge clk); bus.err_clear = 1'b0;
    #1;
    chk("clear ovf",   bus.err_overflow, 0);
    chk("clear drops", bus.err_drop_count, 0);
    exp_drops = 0;

    // Randomized traffic with random per-channel backpressure.
    sent = 0;
    for (int c = 0; c < 3000 && sent < 60; c++) begin
      @(negedge clk);
      bus.ctrl_ready = NC'($urandom);
      if (bus.fifo_level < 12 && $urandom_range(0, 1) == 1) begin
        r = int'($urandom_range(0, 9));
        if (r < 7)      a = {4'($urandom_range(0, NC - 1)), 4'($urandom_range(0, NP - 1))};
        else if (r < 9) a = 8'($urandom);
        else            a = 8'hFF;
        w = {a, 24'($urandom)};
        bus.axi_data     = w;
        bus.axi_write_en = 1'b1;
        model_push(w);
        sent++;
      end else begin
        bus.axi_write_en = 1'b0;
      end
    end
    idle();
    bus.ctrl_ready = '1;
    drain("random", 3000, 1'b0);
    chk("random ovf", bus.err_overflow, 0);

    // Asynchronous reset in the middle of a broadcast with a word still queued.
    push(32'hFF0000AA);
    push(32'h10000001);
    idle();
    t = 0;
    while (act_q.size() < 5 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    #2;
    chk("pre-reset strobe", bus.ctrl_write_en != '0, 1);
    chk("pre-reset level",  bus.fifo_level, 1);
    rst_n = 1'b0;
    #1;
    chk("async rst we",    bus.ctrl_write_en, 0);
    chk("async rst level", bus.fifo_level, 0);
    chk("async rst addr",  bus.ctrl_address, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    act_q.delete();
    exp_q.delete();
    exp_drops = 0;
    push(32'h30000001); model_push(32'h30000001);
    idle();
    drain("post_reset", 50, 1'b0);

    // Broadcast disabled: 8'hFF decodes as channel 15 and is dropped.
    @(negedge clk); bus_b.axi_data = 32'hFF000000; bus_b.axi_write_en = 1'b1;
    @(negedge clk); bus_b.axi_data = 32'h1200AAAA;
    @(negedge clk); bus_b.axi_write_en = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("nobcast drops",   bus_b.err_drop_count, 1);
    chk("nobcast strobes", nb_cnt, 1);
    chk("nobcast strobe",  pk(nb_last), 64'({8'd1, 8'd2, 24'h00AAAA}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
